memory_pipeline: RTL and testbench

//  MEM stage: consumes the EX/MEM register outputs and runs loads/stores on a req/gnt/rvalid data-memory bus.

---
 rtl/memory_pipeline.sv | 196 +++++++++++++++++++
 tb/tb_memory_pipeline.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_pipeline.sv
// rtl/memory_pipeline.sv - MEM stage: data-memory load/store FSM, branch resolve, MEM/WB register
// Optional build macro MISALIGN_TRAP_EN: suppresses misaligned accesses and adds misalign_W.
module memory_pipeline #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              branch_M,
    input  logic              branch_flag_M,
    input  logic              reg_we_M,
    input  logic              mem_we_M,
    input  logic              mem_re_M,
    input  logic              mem_to_reg_M,
    input  logic [4:0]        rd_M,
    input  logic [15:0]       pc_plus4M,
    input  logic [31:0]       ALU_out_M,
    input  logic [15:0]       dest_pc_M,
    input  logic [2:0]        mem_read_type_M,
    input  logic [1:0]        mem_store_type_M,
    input  logic [31:0]       reg2_din_M,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,
    output logic              pc_src_M,
    output logic [15:0]       dest_pc_out,
    output logic              stall_M,
    output logic              reg_we_W,
    output logic              mem_to_reg_W,
    output logic [4:0]        rd_W,
    output logic [15:0]       pc_plus4W,
    output logic [31:0]       ALU_out_W,
`ifdef MISALIGN_TRAP_EN
    output logic              misalign_W,
`endif
    output logic [31:0]       read_data_W
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t      state_q;
    logic [1:0]  lane;
    logic        half_acc;
    logic        word_acc;
    logic        misalign;
    logic        access;
    logic        done;
    logic        req_raw;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    logic        reg_we_q;
    logic        mem_to_reg_q;
    logic [4:0]  rd_q;
    logic [15:0] pc_plus4_q;
    logic [31:0] alu_out_q;
    logic [31:0] read_data_q;

    assign lane     = ALU_out_M[1:0];
    assign half_acc = mem_re_M ? (mem_read_type_M[1:0] == 2'b01)
                               : (mem_we_M && mem_store_type_M == 2'b01);
    assign word_acc = mem_re_M ? mem_read_type_M[1]
                               : (mem_we_M && mem_store_type_M[1]);

`ifdef MISALIGN_TRAP_EN
    assign misalign = (mem_re_M | mem_we_M) &
                      ((half_acc & lane[0]) | (word_acc & (lane != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    assign access      = (mem_re_M | mem_we_M) & ~misalign;
    assign pc_src_M    = branch_M & branch_flag_M;
    assign dest_pc_out = dest_pc_M;
    assign dmem_we     = mem_we_M;

    // Without the trap, sub-word alignment bits are simply dropped on the bus.
    always_comb begin
        dmem_addr = ALU_out_M[ADDR_W-1:0];
        if (half_acc) dmem_addr[0] = 1'b0;
        if (word_acc) dmem_addr[1:0] = 2'b00;
    end

    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = reg2_din_M;
        if (mem_we_M) begin
            case (mem_store_type_M)
                2'b00: begin
                    dmem_be    = 4'b0001 << lane;
                    dmem_wdata = {4{reg2_din_M[7:0]}};
                end
                2'b01: begin
                    dmem_be    = 4'b0011 << {lane[1], 1'b0};
                    dmem_wdata = {2{reg2_din_M[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        byte_sel = dmem_rdata[{lane, 3'b000} +: 8];
        half_sel = dmem_rdata[{lane[1], 4'b0000} +: 16];
        case (mem_read_type_M[1:0])
            2'b00:   load_ext = {{24{byte_sel[7] & ~mem_read_type_M[2]}}, byte_sel};
            2'b01:   load_ext = {{16{half_sel[15] & ~mem_read_type_M[2]}}, half_sel};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        done    = 1'b0;
        req_raw = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_raw = access;
                done    = access & dmem_gnt & (mem_we_M | dmem_rvalid);
            end
            S_REQ: begin
                req_raw = 1'b1;
                done    = dmem_gnt & (mem_we_M | dmem_rvalid);
            end
            S_RESP:  done = dmem_rvalid;
            default: ;
        endcase
    end

    // Reset must drop the request in the same cycle, not at the next edge.
    assign dmem_req = req_raw & ~reset;
    assign stall_M  = access & ~done & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_REQ: begin
                    if (!access && state_q == S_IDLE)
                        state_q <= S_IDLE;
                    else if (!dmem_gnt)
                        state_q <= S_REQ;
                    else if (mem_re_M && !dmem_rvalid)
                        state_q <= S_RESP;
                    else
                        state_q <= S_IDLE;
                end
                S_RESP:  if (dmem_rvalid) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_we_q     <= 1'b0;
            mem_to_reg_q <= 1'b0;
            rd_q         <= '0;
            pc_plus4_q   <= '0;
            alu_out_q    <= '0;
            read_data_q  <= '0;
        end else if (stall_M) begin
            reg_we_q     <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            reg_we_q     <= reg_we_M & ~misalign;
            mem_to_reg_q <= mem_to_reg_M;
            rd_q         <= rd_M;
            pc_plus4_q   <= pc_plus4M;
            alu_out_q    <= ALU_out_M;
            read_data_q  <= mem_re_M ? load_ext : 32'h0;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic misalign_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) misalign_q <= 1'b0;
        else       misalign_q <= misalign;
    end
    assign misalign_W = misalign_q;
`endif

    assign reg_we_W     = reg_we_q;
    assign mem_to_reg_W = mem_to_reg_q;
    assign rd_W         = rd_q;
    assign pc_plus4W    = pc_plus4_q;
    assign ALU_out_W    = alu_out_q;
    assign read_data_W  = read_data_q;

endmodule

// File: tb/tb_memory_pipeline.sv
// tb/tb_memory_pipeline.sv - directed and randomized checks of memory_pipeline against a behavioural model
module tb_memory_pipeline;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch_M, branch_flag_M, reg_we_M, mem_we_M, mem_re_M, mem_to_reg_M;
    logic [4:0]  rd_M;
    logic [15:0] pc_plus4M, dest_pc_M;
    logic [31:0] ALU_out_M, reg2_din_M;
    logic [2:0]  mem_read_type_M;
    logic [1:0]  mem_store_type_M;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [15:0] dmem_addr;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        pc_src_M, stall_M, reg_we_W, mem_to_reg_W;
    logic [15:0] dest_pc_out, pc_plus4W;
    logic [4:0]  rd_W;
    logic [31:0] ALU_out_W, read_data_W;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_W;
`endif

    int checks = 0;
    int failures = 0;

    memory_pipeline #(.ADDR_W(16)) dut (
        .clk(clk), .reset(reset),
        .branch_M(branch_M), .branch_flag_M(branch_flag_M), .reg_we_M(reg_we_M),
        .mem_we_M(mem_we_M), .mem_re_M(mem_re_M), .mem_to_reg_M(mem_to_reg_M),
        .rd_M(rd_M), .pc_plus4M(pc_plus4M), .ALU_out_M(ALU_out_M), .dest_pc_M(dest_pc_M),
        .mem_read_type_M(mem_read_type_M), .mem_store_type_M(mem_store_type_M),
        .reg2_din_M(reg2_din_M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .pc_src_M(pc_src_M), .dest_pc_out(dest_pc_out), .stall_M(stall_M),
        .reg_we_W(reg_we_W), .mem_to_reg_W(mem_to_reg_W), .rd_W(rd_W),
        .pc_plus4W(pc_plus4W), .ALU_out_W(ALU_out_W),
`ifdef MISALIGN_TRAP_EN
        .misalign_W(misalign_W),
`endif
        .read_data_W(read_data_W)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int acc_size();
        if (mem_re_M) return (mem_read_type_M[1:0] == 2'b00) ? 1 : (mem_read_type_M[1:0] == 2'b01) ? 2 : 4;
        return (mem_store_type_M == 2'b00) ? 1 : (mem_store_type_M == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [31:0] w, input int a);
        logic [31:0] b, h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * (a / 2))) & 32'hFFFF;
        case (t)
            3'b000:  return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'b001:  return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    task automatic set_op(input logic br, input logic fl, input logic rwe, input logic re,
                          input logic we, input logic m2r, input logic [4:0] rd,
                          input logic [15:0] pc4, input logic [31:0] alu, input logic [15:0] dpc,
                          input logic [2:0] rt, input logic [1:0] st, input logic [31:0] din);
        branch_M = br; branch_flag_M = fl; reg_we_M = rwe; mem_re_M = re; mem_we_M = we;
        mem_to_reg_M = m2r; rd_M = rd; pc_plus4M = pc4; ALU_out_M = alu; dest_pc_M = dpc;
        mem_read_type_M = rt; mem_store_type_M = st; reg2_din_M = din;
    endtask

    // Runs the currently applied op; gnt arrives g cycles in, rvalid r cycles after gnt.
    task automatic exec(input int g, input int r, input logic [31:0] rdata);
        logic        acc, mis;
        int          last, a, sz;
        logic [31:0] exp_rd, exp_be, exp_wd, exp_addr;
        a   = int'(ALU_out_M[1:0]);
        sz  = acc_size();
        mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis = (mem_re_M || mem_we_M) && (a % sz != 0);
`endif
        acc      = (mem_re_M || mem_we_M) && !mis;
        last     = !acc ? 0 : mem_we_M ? g : g + r;
        exp_rd   = mem_re_M ? ref_load(mem_read_type_M, rdata, a) : 32'h0;
        exp_addr = (ALU_out_M & 32'hFFFF) - ((ALU_out_M & 32'hFFFF) % sz);
        exp_be   = mem_we_M ? ((32'd1 << sz) - 1) << (a - a % sz) : 32'hF;
        exp_wd   = (sz == 1) ? reg2_din_M[7:0] * 32'h01010101 :
                   (sz == 2) ? reg2_din_M[15:0] * 32'h00010001 : reg2_din_M;
        if (!mem_we_M) exp_wd = reg2_din_M;
        for (int k = 0; k <= last; k++) begin
            dmem_gnt    = acc && (k == g);
            dmem_rvalid = acc && mem_re_M && (k == g + r);
            dmem_rdata  = dmem_rvalid ? rdata : $urandom();
            @(negedge clk);
            chk("pc_src", pc_src_M, branch_M & branch_flag_M);
            chk("dest_pc", dest_pc_out, dest_pc_M);
            chk("stall", stall_M, acc && k != last);
            chk("req", dmem_req, acc && k <= g);
            if (acc && k <= g) begin
                chk("addr", dmem_addr, exp_addr);
                chk("we", dmem_we, mem_we_M);
                chk("be", dmem_be, exp_be);
                if (mem_we_M) chk("wdata", dmem_wdata, exp_wd);
            end
            @(posedge clk); #1;
            if (k != last) begin
                chk("bubble_reg_we", reg_we_W, 0);
                chk("bubble_m2r", mem_to_reg_W, 0);
            end else begin
                chk("reg_we_W", reg_we_W, reg_we_M && !mis);
                chk("m2r_W", mem_to_reg_W, mem_to_reg_M);
                chk("rd_W", rd_W, rd_M);
                chk("pc4_W", pc_plus4W, pc_plus4M);
                chk("alu_W", ALU_out_W, ALU_out_M);
                if (mem_re_M) chk("rdata_W", read_data_W, exp_rd);
`ifdef MISALIGN_TRAP_EN
                chk("misalign_W", misalign_W, mis);
`endif
            end
        end
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        int kind;
        logic [2:0] rts[5];
        rts = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        reset = 1'b1;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        set_op(0, 0, 1, 1, 0, 1, 5'd3, 16'h1234, 32'h0000_0010, 16'h0, 3'b010, 2'b00, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", dmem_req, 0);
        chk("rst_stall", stall_M, 0);
        chk("rst_reg_we", reg_we_W, 0);
        chk("rst_alu_W", ALU_out_W, 0);
        chk("rst_rdata_W", read_data_W, 0);
        reset = 1'b0;

        set_op(0, 0, 0, 0, 1, 0, 5'd0, 16'h0004, 32'h0000_0010, 16'h0, 3'b000, 2'b10, 32'hDEADBEEF);
        exec(0, 0, 32'h0);
        set_op(0, 0, 1, 1, 0, 1, 5'd7, 16'h0008, 32'h0000_0013, 16'h0, 3'b000, 2'b00, 32'h0);
        exec(2, 0, 32'h80FF0000);
        set_op(0, 0, 1, 1, 0, 1, 5'd9, 16'h000C, 32'h0000_0012, 16'h0, 3'b101, 2'b00, 32'h0);
        exec(1, 2, 32'h9ABC1234);
        set_op(0, 0, 0, 0, 1, 0, 5'd0, 16'h0010, 32'h0000_0001, 16'h0, 3'b000, 2'b00, 32'h11223344);
        exec(0, 0, 32'h0);
        set_op(1, 1, 0, 0, 0, 0, 5'd0, 16'h0014, 32'h0000_0000, 16'h0040, 3'b000, 2'b00, 32'h0);
        exec(0, 0, 32'h0);
`ifdef MISALIGN_TRAP_EN
        set_op(0, 0, 1, 1, 0, 1, 5'd4, 16'h0018, 32'h0000_0002, 16'h0, 3'b010, 2'b00, 32'h0);
        exec(0, 0, 32'h0);
`endif

        set_op(0, 0, 1, 1, 0, 1, 5'd5, 16'h001C, 32'h0000_0020, 16'h0, 3'b010, 2'b00, 32'h0);
        dmem_gnt = 1'b0;
        @(posedge clk); #1;
        chk("req_in_REQ", dmem_req, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_req", dmem_req, 0);
        chk("rst_mid_stall", stall_M, 0);
        chk("rst_mid_alu_W", ALU_out_W, 0);
        chk("rst_mid_pc4_W", pc_plus4W, 0);
        chk("rst_mid_rd_W", rd_W, 0);
        set_op(0, 0, 0, 0, 0, 0, 5'd0, 16'h0, 32'h0, 16'h0, 3'b000, 2'b00, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 2);
            set_op(kind == 0 ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), kind == 1, kind == 2, 1'($urandom_range(0, 1)),
                   5'($urandom()), 16'($urandom()), $urandom(), 16'($urandom()),
                   rts[$urandom_range(0, 4)], 2'($urandom_range(0, 2)), $urandom());
            exec($urandom_range(0, 2), $urandom_range(0, 2), $urandom());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
